// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory arbiter slice.
package dmem_pkg;

   localparam int unsigned DMEM_WORDS = 64;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_DBG_ACK = 1'b1
   } dmem_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_DBG  = 2'd2
   } dmem_gnt_e;

endpackage

// File: rtl/dmem_fault_check.sv
// Flags a word access that is misaligned or beyond the end of the data memory.
module dmem_fault_check
   import dmem_pkg::*;
#(
   parameter int unsigned WORDS = DMEM_WORDS
) (
   input  logic [31:0] addr_i,
   output logic        fault_o
);

   localparam logic [32:0] ADDR_LIMIT = 33'(4 * WORDS);

   assign fault_o = (addr_i[1:0] != 2'b00) || ({1'b0, addr_i} >= ADDR_LIMIT);

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data memory between the MEM stage (same-cycle access)
// and the debug host (req/ack with a registered response), with starvation relief.
module data_memory_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned WORDS        = DMEM_WORDS,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic [31:0] dbg_rdata,
   output logic        dbg_ack,
   output logic        access_fault,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data_write,
   input  logic [31:0] mem_data_read
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   dmem_state_e state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic        dbg_ack_q;
   logic [31:0] dbg_rdata_q;
   logic        fault_q;

   dmem_gnt_e   gnt;
   logic        dbg_want;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        addr_fault;
   logic        granted_fault;
   logic [31:0] rd_data;

   // DBG is only eligible in IDLE, so a held request cannot re-win in its ack cycle.
   always_comb begin
      dbg_want = dbg_req && (state_q == ST_IDLE);
      gnt      = GNT_NONE;
      if (cpu_req && dbg_want) begin
         gnt = (starve_q >= LIMIT) ? GNT_DBG : GNT_CPU;
      end else if (cpu_req) begin
         gnt = GNT_CPU;
      end else if (dbg_want) begin
         gnt = GNT_DBG;
      end
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      unique case (gnt)
         GNT_CPU: begin
            sel_we    = cpu_we;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
         end
         GNT_DBG: begin
            sel_we    = dbg_we;
            sel_addr  = dbg_addr;
            sel_wdata = dbg_wdata;
         end
         default: ;
      endcase
   end

   dmem_fault_check #(
      .WORDS (WORDS)
   ) u_fault_check (
      .addr_i  (sel_addr),
      .fault_o (addr_fault)
   );

   assign granted_fault  = (gnt != GNT_NONE) && addr_fault;
   assign mem_read       = (gnt != GNT_NONE) && !sel_we && !addr_fault;
   assign mem_write      = (gnt != GNT_NONE) &&  sel_we && !addr_fault;
   assign mem_address    = sel_addr;
   assign mem_data_write = sel_wdata;
   assign rd_data        = mem_read ? mem_data_read : '0;

   assign cpu_rdata = (gnt == GNT_CPU) ? rd_data : '0;
   assign cpu_stall = cpu_req && (gnt != GNT_CPU);

   always_comb begin
      state_d  = (gnt == GNT_DBG) ? ST_DBG_ACK : ST_IDLE;
      starve_d = starve_q;
      if (gnt == GNT_DBG) begin
         starve_d = '0;
      end else if (dbg_want && (starve_q != 4'hF)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         starve_q    <= '0;
         dbg_ack_q   <= 1'b0;
         dbg_rdata_q <= '0;
         fault_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         dbg_ack_q <= (gnt == GNT_DBG);
         fault_q   <= granted_fault;
         if (gnt == GNT_DBG) begin
            dbg_rdata_q <= rd_data;
         end
      end
   end

   assign dbg_ack      = dbg_ack_q;
   assign dbg_rdata    = dbg_rdata_q;
   assign access_fault = fault_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Randomised and directed bench for data_memory_arbiter against a behavioural model.
module tb_data_memory_arbiter;

   localparam int unsigned WORDS = 64;
   localparam int unsigned LIMIT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dbg_req, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic        dbg_ack, access_fault;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_data_write, mem_data_read;

   data_memory_arbiter #(
      .WORDS        (WORDS),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_rdata      (cpu_rdata),
      .cpu_stall      (cpu_stall),
      .dbg_req        (dbg_req),
      .dbg_we         (dbg_we),
      .dbg_addr       (dbg_addr),
      .dbg_wdata      (dbg_wdata),
      .dbg_rdata      (dbg_rdata),
      .dbg_ack        (dbg_ack),
      .access_fault   (access_fault),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_address    (mem_address),
      .mem_data_write (mem_data_write),
      .mem_data_read  (mem_data_read)
   );

   always #5 clk = ~clk;

   // Data memory: combinational read, write on the falling edge.
   logic [31:0] ram [WORDS];
   bit          ram_init = 1'b1;

   function automatic logic [31:0] seed_word(input int unsigned i);
      return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
   endfunction

   assign mem_data_read = ram[mem_address[7:2]];

   always @(negedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < int'(WORDS); i++) ram[i] <= seed_word(i);
      end else if (mem_write) begin
         ram[mem_address[7:2]] <= mem_data_write;
      end
   end

   int          checks = 0;
   int          errors = 0;
   logic [31:0] shadow [WORDS];
   int          m_starve;
   bit          m_in_ack, m_ack_exp, m_fault_exp;
   logic [31:0] m_rdata_exp;
   bit          cap_stall, cap_mr, cap_mw;
   logic [31:0] cap_rdata, cap_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                        input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
      cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
      dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
   endtask

   // Called at posedge+1 with inputs driven; checks the cycle and its registered result.
   task automatic cycle(input bit rst_mid);
      int          who;
      bit          elig, bad, we;
      logic [31:0] addr, wdata, exp_rd;
      #2;
      elig = !m_in_ack;
      if (cpu_req && !(dbg_req && elig && m_starve >= int'(LIMIT))) who = 1;
      else if (dbg_req && elig) who = 2;
      else who = 0;
      addr  = (who == 1) ? cpu_addr  : (who == 2) ? dbg_addr  : 32'h0;
      wdata = (who == 1) ? cpu_wdata : (who == 2) ? dbg_wdata : 32'h0;
      we    = (who == 1) ? cpu_we    : (who == 2) ? dbg_we    : 1'b0;
      bad   = (who != 0) && ((addr % 4) != 0 || addr >= 4 * WORDS);
      exp_rd = (who != 0 && !we && !bad) ? shadow[addr[7:2]] : 32'h0;
      chk("mem_read",       32'(mem_read),  32'(who != 0 && !we && !bad));
      chk("mem_write",      32'(mem_write), 32'(who != 0 &&  we && !bad));
      chk("mem_address",    mem_address,    addr);
      chk("mem_data_write", mem_data_write, wdata);
      chk("cpu_rdata",      cpu_rdata,      (who == 1) ? exp_rd : 32'h0);
      chk("cpu_stall",      32'(cpu_stall), 32'(cpu_req && who != 1));
      cap_stall = cpu_stall; cap_mr = mem_read; cap_mw = mem_write;
      cap_rdata = cpu_rdata; cap_addr = mem_address;
      if (who == 2) begin
         m_ack_exp   = 1'b1;
         m_rdata_exp = exp_rd;
         m_starve    = 0;
      end else begin
         m_ack_exp = 1'b0;
         if (dbg_req && elig && m_starve < 15) m_starve++;
      end
      m_fault_exp = bad;
      m_in_ack    = (who == 2);
      if (who != 0 && we && !bad) shadow[addr[7:2]] = wdata;
      if (rst_mid) begin
         #1 reset = 1'b1;
         m_starve = 0; m_in_ack = 0; m_ack_exp = 0; m_fault_exp = 0; m_rdata_exp = '0;
      end
      @(posedge clk);
      #1;
      chk("dbg_ack", 32'(dbg_ack), 32'(m_ack_exp));
      if (m_ack_exp) chk("dbg_rdata", dbg_rdata, m_rdata_exp);
      chk("access_fault", 32'(access_fault), 32'(m_fault_exp));
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, WORDS - 1)) << 2;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      else if (r == 1) a = 32'(4 * WORDS) + (32'($urandom_range(0, 255)) << 2);
      else if (r == 2) a = $urandom();
      return a;
   endfunction

   initial begin
      bit held;
      bit d_act;
      int d_wait;
      m_starve = 0; m_in_ack = 0; m_ack_exp = 0; m_fault_exp = 0; m_rdata_exp = '0;
      cap_stall = 0;
      for (int i = 0; i < int'(WORDS); i++) shadow[i] = seed_word(i);
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dbg_ack",      32'(dbg_ack),      32'h0);
      chk("rst_dbg_rdata",    dbg_rdata,         32'h0);
      chk("rst_access_fault", 32'(access_fault), 32'h0);
      chk("rst_mem_read",     32'(mem_read),     32'h0);
      chk("rst_mem_write",    32'(mem_write),    32'h0);
      chk("rst_mem_address",  mem_address,       32'h0);
      chk("rst_cpu_stall",    32'(cpu_stall),    32'h0);
      ram_init = 1'b0;
      reset    = 1'b0;

      for (int c = 0; c < 3; c++) begin
         cycle(0);
         chk("idle_mem_strobes", {30'h0, cap_mr, cap_mw}, 32'h0);
         chk("idle_stall", 32'(cap_stall), 32'h0);
         chk("idle_addr", cap_addr, 32'h0);
      end

      // CPU write then read
      drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0);
      cycle(0);
      chk("cpu_wr_stall", 32'(cap_stall), 32'h0);
      drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0);
      cycle(0);
      chk("cpu_rd_data", cap_rdata, 32'hDEADBEEF);
      chk("cpu_rd_stall", 32'(cap_stall), 32'h0);

      // DBG write then a read re-asserted in the ack cycle
      drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678);
      cycle(0);
      chk("dbg_wr_ack", 32'(dbg_ack), 32'h1);
      drive(0, 0, 0, 0, 1, 0, 32'h20, 32'h0);
      cycle(0);
      chk("dbg_no_b2b", 32'(dbg_ack), 32'h0);
      cycle(0);
      chk("dbg_rd_ack", 32'(dbg_ack), 32'h1);
      chk("dbg_rd_data", dbg_rdata, 32'h12345678);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0);

      // Starvation: CPU every cycle, DBG from cycle 0
      held = 1'b1;
      for (int c = 0; c < 7; c++) begin
         drive(1, 0, 32'h10, 0, held, 0, 32'h20, 0);
         cycle(0);
         chk("starve_stall", 32'(cap_stall), 32'(c == 4));
         chk("starve_ack", 32'(dbg_ack), 32'(c == 4));
         if (dbg_ack) held = 1'b0;
      end

      // Faulting accesses leave memory untouched
      drive(1, 1, 32'h0, 32'h0BADF00D, 0, 0, 0, 0);
      cycle(0);
      drive(1, 0, 32'h02, 32'h0, 0, 0, 0, 0);
      cycle(0);
      chk("flt_rd_strobes", {30'h0, cap_mr, cap_mw}, 32'h0);
      chk("flt_rd_data", cap_rdata, 32'h0);
      chk("flt_rd_pulse", 32'(access_fault), 32'h1);
      drive(1, 1, 32'h100, 32'hCAFEF00D, 0, 0, 0, 0);
      cycle(0);
      chk("flt_wr_strobes", {30'h0, cap_mr, cap_mw}, 32'h0);
      chk("flt_wr_pulse", 32'(access_fault), 32'h1);
      drive(1, 0, 32'h0, 32'h0, 0, 0, 0, 0);
      cycle(0);
      chk("flt_mem_kept", cap_rdata, 32'h0BADF00D);
      chk("flt_pulse_end", 32'(access_fault), 32'h0);
      drive(0, 0, 0, 0, 1, 0, 32'h103, 0);
      cycle(0);
      chk("flt_dbg_ack", 32'(dbg_ack), 32'h1);
      chk("flt_dbg_data", dbg_rdata, 32'h0);
      chk("flt_dbg_pulse", 32'(access_fault), 32'h1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0);

      // Reset during a DBG grant cycle drops the ack
      drive(0, 0, 0, 0, 1, 0, 32'h20, 0);
      cycle(1);
      chk("rstmid_ack", 32'(dbg_ack), 32'h0);
      chk("rstmid_rdata", dbg_rdata, 32'h0);
      reset = 1'b0;
      cycle(0);
      chk("rstmid_fresh_ack", 32'(dbg_ack), 32'h1);
      chk("rstmid_fresh_data", dbg_rdata, 32'h12345678);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0);

      // Random traffic
      d_act = 1'b0;
      d_wait = 0;
      cap_stall = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (d_act && dbg_ack) begin
            checks++;
            if (d_wait > int'(LIMIT) + 2) begin
               errors++;
               $display("FAIL dbg_latency waited %0d cycles, allowed %0d", d_wait, LIMIT + 2);
            end
            d_act = 1'b0;
         end else if (d_act && d_wait > int'(LIMIT) + 2) begin
            checks++;
            errors++;
            $display("FAIL dbg_grant_bound no ack after %0d cycles, allowed %0d", d_wait, LIMIT + 2);
            d_act = 1'b0;
         end
         if (!d_act && $urandom_range(0, 3) == 0) begin
            d_act     = 1'b1;
            d_wait    = 0;
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = rand_addr();
            dbg_wdata = $urandom();
         end
         dbg_req = d_act;
         if (d_act) d_wait++;
         if (!cap_stall) begin
            cpu_req   = ($urandom_range(0, 9) < 7);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = rand_addr();
            cpu_wdata = $urandom();
         end
         cycle(0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
